fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register.
- Holds the PC and issues requests to instruction memory over a variable-latency req/valid handshake.
- Obeys the stall controls produced by the load-use hazard logic (pc_write, IFID_write) and the branch flush from EX.
- Feeds the decode stage with {pc, pc+1, instruction, valid}.

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 203 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus used by the fetch stage.
// The master (fetch stage) drives a request and address. The slave (memory)
// answers with a one-cycle valid strobe and the instruction word.
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC and fetches over a variable-latency req/valid handshake.
// It honours the load-use stall (pc_write / IFID_write) and the branch flush from EX.
// States: FETCH (request outstanding), HOLD (a response arrived during a stall
// and is parked in a buffer), and DRAIN (a flush arrived while a request was in
// flight, so the request must finish before the redirect is taken).
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/bubble counters.
module fetch_stage #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = {PC_WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_write,
  input  logic                   IFID_write,
  input  logic                   flush,
  input  logic [PC_WIDTH-1:0]    branch_target,
  fetch_stage_if.master          imem,
  output logic [PC_WIDTH-1:0]    IFID_pc,
  output logic [PC_WIDTH-1:0]    IFID_pc_plus1,
  output logic [INSTR_WIDTH-1:0] IFID_instr,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]            stall_cycles,
  output logic [15:0]            bubble_cycles,
`endif
  output logic                   IFID_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0]    PC_ONE     = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP  = {INSTR_WIDTH{1'b0}};

  state_t                 state_r, state_nx_s;
  logic [PC_WIDTH-1:0]    pc_r, pc_nx_s;
  logic [PC_WIDTH-1:0]    redir_r, redir_nx_s;
  logic [INSTR_WIDTH-1:0] buf_r, buf_nx_s;
  logic                   req_r;
  logic [PC_WIDTH-1:0]    ifid_pc_r, ifid_pc_nx_s;
  logic [PC_WIDTH-1:0]    ifid_pc1_r, ifid_pc1_nx_s;
  logic [INSTR_WIDTH-1:0] ifid_instr_r, ifid_instr_nx_s;
  logic                   ifid_valid_r, ifid_valid_nx_s;
  logic                   stall_s;
  logic                   bubble_s;
  logic [PC_WIDTH-1:0]    pc_inc_s;

  // Either stall input low freezes the whole front end.
  assign stall_s  = ~pc_write | ~IFID_write;
  assign pc_inc_s = pc_r + PC_ONE;

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;
  assign IFID_pc        = ifid_pc_r;
  assign IFID_pc_plus1  = ifid_pc1_r;
  assign IFID_instr     = ifid_instr_r;
  assign IFID_valid     = ifid_valid_r;

  // Next-state and IF/ID load decisions; priority is flush > stall > advance.
  always_comb begin
    state_nx_s      = state_r;
    pc_nx_s         = pc_r;
    redir_nx_s      = redir_r;
    buf_nx_s        = buf_r;
    ifid_pc_nx_s    = ifid_pc_r;
    ifid_pc1_nx_s   = ifid_pc1_r;
    ifid_instr_nx_s = ifid_instr_r;
    ifid_valid_nx_s = ifid_valid_r;
    bubble_s        = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (imem.imem_valid) begin
          if (flush) begin
            pc_nx_s         = branch_target;
            ifid_valid_nx_s = 1'b0;
            ifid_instr_nx_s = INSTR_NOP;
          end else if (stall_s) begin
            buf_nx_s   = imem.imem_rdata;
            state_nx_s = S_HOLD;
          end else begin
            ifid_pc_nx_s    = pc_r;
            ifid_pc1_nx_s   = pc_inc_s;
            ifid_instr_nx_s = imem.imem_rdata;
            ifid_valid_nx_s = 1'b1;
            pc_nx_s         = pc_inc_s;
          end
        end else begin
          if (flush) begin
            redir_nx_s      = branch_target;
            ifid_valid_nx_s = 1'b0;
            ifid_instr_nx_s = INSTR_NOP;
            state_nx_s      = S_DRAIN;
          end else if (stall_s) begin
            state_nx_s = S_FETCH;
          end else begin
            ifid_valid_nx_s = 1'b0;
            ifid_instr_nx_s = INSTR_NOP;
            bubble_s        = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          pc_nx_s         = branch_target;
          ifid_valid_nx_s = 1'b0;
          ifid_instr_nx_s = INSTR_NOP;
          state_nx_s      = S_FETCH;
        end else if (stall_s) begin
          state_nx_s = S_HOLD;
        end else begin
          ifid_pc_nx_s    = pc_r;
          ifid_pc1_nx_s   = pc_inc_s;
          ifid_instr_nx_s = buf_r;
          ifid_valid_nx_s = 1'b1;
          pc_nx_s         = pc_inc_s;
          state_nx_s      = S_FETCH;
        end
      end
      S_DRAIN: begin
        // The in-flight request cannot be withdrawn; the latest flush target wins.
        bubble_s = 1'b1;
        if (flush) begin
          redir_nx_s = branch_target;
        end else begin
          redir_nx_s = redir_r;
        end
        if (imem.imem_valid) begin
          pc_nx_s    = flush ? branch_target : redir_r;
          state_nx_s = S_FETCH;
        end else begin
          state_nx_s = S_DRAIN;
        end
      end
      default: begin
        state_nx_s = S_FETCH;
      end
    endcase
  end

  // State, PC, buffers and the registered request strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
      pc_r    <= RESET_PC;
      redir_r <= {PC_WIDTH{1'b0}};
      buf_r   <= INSTR_NOP;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      pc_r    <= pc_nx_s;
      redir_r <= redir_nx_s;
      buf_r   <= buf_nx_s;
      req_r   <= (state_nx_s != S_HOLD);
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_pc_r    <= {PC_WIDTH{1'b0}};
      ifid_pc1_r   <= {PC_WIDTH{1'b0}};
      ifid_instr_r <= INSTR_NOP;
      ifid_valid_r <= 1'b0;
    end else begin
      ifid_pc_r    <= ifid_pc_nx_s;
      ifid_pc1_r   <= ifid_pc1_nx_s;
      ifid_instr_r <= ifid_instr_nx_s;
      ifid_valid_r <= ifid_valid_nx_s;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] bubble_cnt_r;

  assign stall_cycles  = stall_cnt_r;
  assign bubble_cycles = bubble_cnt_r;

  // Saturating counters for stall cycles and latency/drain bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r  <= 16'h0000;
      bubble_cnt_r <= 16'h0000;
    end else begin
      if (stall_s && !flush && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (bubble_s && (bubble_cnt_r != 16'hFFFF)) begin
        bubble_cnt_r <= bubble_cnt_r + 16'h0001;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a directed per-cycle vector table, then a
// randomized run against a queue-based reference model of the fetch rules.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, IFID_write, flush;
  logic [7:0]  branch_target;
  logic [7:0]  IFID_pc, IFID_pc_plus1;
  logic [31:0] IFID_instr;
  logic        IFID_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cycles, bubble_cycles;
`endif

  always #5 clk = ~clk;

  fetch_stage_if #(.PC_WIDTH(8), .INSTR_WIDTH(32)) bus ();

  fetch_stage #(.PC_WIDTH(8), .INSTR_WIDTH(32), .RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .IFID_write    (IFID_write),
    .flush         (flush),
    .branch_target (branch_target),
    .imem          (bus),
    .IFID_pc       (IFID_pc),
    .IFID_pc_plus1 (IFID_pc_plus1),
    .IFID_instr    (IFID_instr),
`ifdef FETCH_PERF_CNT_EN
    .stall_cycles  (stall_cycles),
    .bubble_cycles (bubble_cycles),
`endif
    .IFID_valid    (IFID_valid)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One directed cycle: inputs applied for the cycle, outputs expected after the edge.
  typedef struct {
    logic        pw, iw, fl;
    logic [7:0]  bt;
    logic        v;
    logic [31:0] rd;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_val;
    logic [7:0]  e_pc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(input logic pw, input logic iw, input logic fl, input logic [7:0] bt,
                              input logic v, input logic [31:0] rd, input logic e_req,
                              input logic [7:0] e_addr, input logic e_val, input logic [7:0] e_pc,
                              input logic [31:0] e_instr);
    vec_t r;
    r.pw = pw; r.iw = iw; r.fl = fl; r.bt = bt; r.v = v; r.rd = rd;
    r.e_req = e_req; r.e_addr = e_addr; r.e_val = e_val; r.e_pc = e_pc; r.e_instr = e_instr;
    return r;
  endfunction

  // Reference model state: parked response and pending redirect as queues.
  logic [7:0]  m_pc;
  logic [31:0] m_hold[$];
  logic [7:0]  m_redir[$];
  logic        m_val;
  logic [7:0]  m_ipc;
  logic [31:0] m_instr;
  logic [31:0] mem [256];

  task automatic model_reset();
    m_pc = 8'h00; m_hold.delete(); m_redir.delete();
    m_val = 1'b0; m_ipc = 8'h00; m_instr = 32'h0;
  endtask

  task automatic model_step(input logic s, input logic f, input logic [7:0] bt,
                            input logic v, input logic [31:0] rd);
    if (m_hold.size() != 0) begin
      if (f) begin
        m_hold.delete(); m_pc = bt; m_val = 1'b0; m_instr = 32'h0;
      end else if (!s) begin
        m_ipc = m_pc; m_instr = m_hold.pop_front(); m_val = 1'b1; m_pc = m_pc + 8'd1;
      end
    end else if (m_redir.size() != 0) begin
      if (f) begin
        m_redir.delete(); m_redir.push_back(bt);
      end
      if (v) m_pc = m_redir.pop_front();
    end else if (v) begin
      if (f) begin
        m_pc = bt; m_val = 1'b0; m_instr = 32'h0;
      end else if (s) begin
        m_hold.push_back(rd);
      end else begin
        m_ipc = m_pc; m_instr = rd; m_val = 1'b1; m_pc = m_pc + 8'd1;
      end
    end else if (f) begin
      m_redir.push_back(bt); m_val = 1'b0; m_instr = 32'h0;
    end else if (!s) begin
      m_val = 1'b0; m_instr = 32'h0;
    end
  endtask

  vec_t        tbl [22];
  logic [7:0]  exp_p1;
  logic        r_s, r_f, r_v;
  logic [7:0]  r_bt;
  logic [31:0] r_rd;
  int          lat, cnt, k;

  initial begin
    // Cycle-by-cycle directed table (memory response driven directly).
    //              pw    iw    fl    bt     v     rdata         req   addr   val   pc     instr
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h00, 1'b0, 8'h00, 32'h0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h11,       1'b1, 8'h01, 1'b1, 8'h00, 32'h11);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h22,       1'b1, 8'h02, 1'b1, 8'h01, 32'h22);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h33,       1'b1, 8'h03, 1'b1, 8'h02, 32'h33);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h44,       1'b0, 8'h03, 1'b1, 8'h02, 32'h33);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h03, 1'b1, 8'h02, 32'h33);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h04, 1'b1, 8'h03, 32'h44);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h55,       1'b1, 8'h05, 1'b1, 8'h04, 32'h55);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h05, 1'b0, 8'h00, 32'h0);
    tbl[9]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h05, 1'b0, 8'h00, 32'h0);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h66,       1'b1, 8'h06, 1'b1, 8'h05, 32'h66);
    tbl[11] = mk(1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 32'h0,        1'b1, 8'h06, 1'b0, 8'h00, 32'h0);
    tbl[12] = mk(1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 32'h0,        1'b1, 8'h06, 1'b0, 8'h00, 32'h0);
    tbl[13] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'hBAD,      1'b1, 8'h40, 1'b0, 8'h00, 32'h0);
    tbl[14] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h77,       1'b1, 8'h41, 1'b1, 8'h40, 32'h77);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h88,       1'b0, 8'h41, 1'b1, 8'h40, 32'h77);
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 32'h0,        1'b1, 8'hFF, 1'b0, 8'h00, 32'h0);
    tbl[17] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h99,       1'b1, 8'h00, 1'b1, 8'hFF, 32'h99);
    tbl[18] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'hAA,       1'b1, 8'h01, 1'b1, 8'h00, 32'hAA);
    tbl[19] = mk(1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 32'hCC,       1'b1, 8'h10, 1'b0, 8'h00, 32'h0);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h10, 1'b0, 8'h00, 32'h0);
    tbl[21] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'hDD,       1'b1, 8'h11, 1'b1, 8'h10, 32'hDD);

    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    // Reset state.
    rst_n = 1'b0; pc_write = 1'b1; IFID_write = 1'b1; flush = 1'b0; branch_target = 8'h00;
    bus.imem_valid = 1'b0; bus.imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
    chk("rst_valid", {31'h0, IFID_valid}, 32'h0);
    chk("rst_instr", IFID_instr, 32'h0);
    chk("rst_pc", {24'h0, IFID_pc}, 32'h0);
    chk("rst_pc1", {24'h0, IFID_pc_plus1}, 32'h0);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 22; i++) begin
      pc_write = tbl[i].pw; IFID_write = tbl[i].iw; flush = tbl[i].fl;
      branch_target = tbl[i].bt; bus.imem_valid = tbl[i].v; bus.imem_rdata = tbl[i].rd;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_req", i), {31'h0, bus.imem_req}, {31'h0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), {24'h0, bus.imem_addr}, {24'h0, tbl[i].e_addr});
      chk($sformatf("tbl%0d_valid", i), {31'h0, IFID_valid}, {31'h0, tbl[i].e_val});
      chk($sformatf("tbl%0d_instr", i), IFID_instr, tbl[i].e_instr);
      if (tbl[i].e_val) begin
        exp_p1 = tbl[i].e_pc + 8'd1;
        chk($sformatf("tbl%0d_pc", i), {24'h0, IFID_pc}, {24'h0, tbl[i].e_pc});
        chk($sformatf("tbl%0d_pc1", i), {24'h0, IFID_pc_plus1}, {24'h0, exp_p1});
      end
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", {16'h0, stall_cycles}, 32'd4);
    chk("perf_bubble", {16'h0, bubble_cycles}, 32'd5);
`endif

    // Reset in the middle of an outstanding request.
    pc_write = 1'b1; IFID_write = 1'b1; flush = 1'b0; bus.imem_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'h0, bus.imem_req}, 32'h0);
    chk("midrst_valid", {31'h0, IFID_valid}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cnt = 0; lat = 1;

    // Randomized run: memory with 1..4 cycle latency, random stalls and flushes.
    for (int c = 0; c < 3000; c++) begin
      r_s  = ($urandom_range(0, 3) == 0);
      r_f  = ($urandom_range(0, 9) == 0);
      r_bt = 8'($urandom);
      k    = $urandom_range(0, 2);
      pc_write   = r_s ? (k == 1) : 1'b1;
      IFID_write = r_s ? (k == 2) : 1'b1;
      r_v = 1'b0; r_rd = 32'h0;
      if (bus.imem_req) begin
        if (cnt == 0) lat = $urandom_range(1, 4);
        cnt++;
        if (cnt >= lat) begin
          r_v = 1'b1; r_rd = mem[bus.imem_addr]; cnt = 0;
        end
      end else begin
        cnt = 0;
      end
      flush = r_f; branch_target = r_bt; bus.imem_valid = r_v; bus.imem_rdata = r_rd;
      model_step(r_s, r_f, r_bt, r_v, r_rd);
      @(posedge clk);
      #1;
      chk("rnd_req", {31'h0, bus.imem_req}, {31'h0, (m_hold.size() == 0)});
      if (m_hold.size() == 0) chk("rnd_addr", {24'h0, bus.imem_addr}, {24'h0, m_pc});
      chk("rnd_valid", {31'h0, IFID_valid}, {31'h0, m_val});
      chk("rnd_instr", IFID_instr, m_instr);
      if (m_val) begin
        exp_p1 = m_ipc + 8'd1;
        chk("rnd_pc", {24'h0, IFID_pc}, {24'h0, m_ipc});
        chk("rnd_pc1", {24'h0, IFID_pc_plus1}, {24'h0, exp_p1});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
